// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared state encoding and mode/direction constants for the
//            CORDIC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } cordic_state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // DIR_NEG selects d_i = -1: x += y>>i, y -= x>>i, z += atan_i
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cordic_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_cnt
// Brief    : Iteration index counter with clear, enable and a terminal-count
//            flag at NUM_ITER-1.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_iter_cnt #(
    parameter  int NUM_ITER = 12,
    localparam int CNT_W    = $clog2(NUM_ITER)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_ITER - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority so the index returns to zero on the terminal cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_seq_ctrl
// Brief    : Sequencer for the iterative CORDIC datapath: load, NUM_ITER
//            micro-rotations with direction decode, then a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter  int BIT_WIDTH = 16,
    parameter  int NUM_ITER  = 12,
    localparam int CNT_W     = $clog2(NUM_ITER)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic             z_sign_in,
    input  logic             y_sign_in,
    output logic             busy_out,
    output logic             load_out,
    output logic             en_out,
    output logic [CNT_W-1:0] iter_out,
    output logic             dir_out,
    output logic             done_out,
    output logic             result_valid_out
);

    generate
        if (NUM_ITER < 2 || NUM_ITER > BIT_WIDTH) begin : g_bad_num_iter
            $error("cordic_seq_ctrl: NUM_ITER must lie in 2..BIT_WIDTH");
        end
    endgenerate

    cordic_state_t    r_state;
    cordic_state_t    w_state_nxt;
    logic             r_mode;
    logic             r_result_valid;
    logic             w_in_iter;
    logic             w_accept;
    logic             w_cnt_clr;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_cnt;

    assign w_in_iter = (r_state == ITER);
    assign w_accept  = (r_state == IDLE) && start_in;
    // The index only advances inside ITER and is parked at zero elsewhere.
    assign w_cnt_clr = ~w_in_iter | w_cnt_tc;

    cordic_iter_cnt #(
        .NUM_ITER (NUM_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (rst_in),
        .i_clr (w_cnt_clr),
        .i_en  (w_in_iter),
        .o_cnt (w_cnt),
        .o_tc  (w_cnt_tc)
    );

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_mode         <= MODE_ROT;
            r_result_valid <= 1'b0;
        end else if (w_accept) begin
            r_mode         <= mode_in;
            r_result_valid <= 1'b0;
        end else if (r_state == DONE) begin
            r_result_valid <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_out    = 1'b0;
        load_out    = 1'b0;
        en_out      = 1'b0;
        done_out    = 1'b0;
        dir_out     = DIR_POS;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy_out    = 1'b1;
                load_out    = 1'b1;
                en_out      = 1'b1;
                w_state_nxt = ITER;
            end
            ITER: begin
                busy_out = 1'b1;
                en_out   = 1'b1;
                // Vectoring drives y toward zero; rotation drives z toward zero.
                if (r_mode == MODE_VEC) begin
                    dir_out = y_sign_in ? DIR_POS : DIR_NEG;
                end else begin
                    dir_out = z_sign_in ? DIR_NEG : DIR_POS;
                end
                if (w_cnt_tc) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy_out    = 1'b1;
                done_out    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign iter_out         = w_cnt;
    assign result_valid_out = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_seq_ctrl
// Brief    : Self-checking bench: timing tables, corner sequences and random
//            stimulus against a cycle-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_seq_ctrl;

    localparam int N  = 12;
    localparam int CW = $clog2(N);
    localparam int TL = N + 6;

    logic          clk       = 1'b0;
    logic          rst_in    = 1'b0;
    logic          start_in  = 1'b0;
    logic          mode_in   = 1'b0;
    logic          z_sign_in = 1'b0;
    logic          y_sign_in = 1'b0;
    logic          busy_out;
    logic          load_out;
    logic          en_out;
    logic [CW-1:0] iter_out;
    logic          dir_out;
    logic          done_out;
    logic          result_valid_out;

    cordic_seq_ctrl #(
        .BIT_WIDTH (16),
        .NUM_ITER  (N)
    ) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .mode_in          (mode_in),
        .z_sign_in        (z_sign_in),
        .y_sign_in        (y_sign_in),
        .busy_out         (busy_out),
        .load_out         (load_out),
        .en_out           (en_out),
        .iter_out         (iter_out),
        .dir_out          (dir_out),
        .done_out         (done_out),
        .result_valid_out (result_valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic mode;
        logic zs;
        logic ys;
        logic busy;
        logic load;
        logic en;
        int   iter;
        logic dir;
        logic done;
        logic valid;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: position within a run (0 = idle, 1 = load, 2..N+1 = iterations,
    // N+2 = done), plus the captured mode and the result-valid level.
    int   m_pos   = 0;
    logic m_mode  = 1'b0;
    logic m_valid = 1'b0;

    vec_t tab_rot  [TL];
    vec_t tab_vec  [TL];
    vec_t tab_dist [TL];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for cycle c of an undisturbed run accepted in cycle 0.
    function automatic vec_t run_vec(input int c, input logic st, input logic md,
                                     input logic zs, input logic ys,
                                     input logic run_mode, input logic valid0);
        vec_t v;
        logic in_it;
        in_it   = (c >= 2) && (c <= N + 1);
        v.start = st;
        v.mode  = md;
        v.zs    = zs;
        v.ys    = ys;
        v.busy  = (c >= 1) && (c <= N + 2);
        v.load  = (c == 1);
        v.en    = (c >= 1) && (c <= N + 1);
        v.iter  = in_it ? c - 2 : 0;
        v.dir   = in_it ? (run_mode ? ~ys : zs) : 1'b0;
        v.done  = (c == N + 2);
        v.valid = (c == 0) ? valid0 : (c >= N + 3);
        return v;
    endfunction

    function automatic vec_t model_vec(input vec_t s);
        vec_t v;
        logic in_it;
        v       = s;
        in_it   = (m_pos >= 2) && (m_pos <= N + 1);
        v.busy  = (m_pos != 0);
        v.load  = (m_pos == 1);
        v.en    = (m_pos >= 1) && (m_pos <= N + 1);
        v.iter  = in_it ? m_pos - 2 : 0;
        v.dir   = in_it ? (m_mode ? ~s.ys : s.zs) : 1'b0;
        v.done  = (m_pos == N + 2);
        v.valid = m_valid;
        return v;
    endfunction

    task automatic model_step(input vec_t s);
        if (m_pos == 0) begin
            if (s.start) begin
                m_pos   = 1;
                m_mode  = s.mode;
                m_valid = 1'b0;
            end
        end else if (m_pos == N + 2) begin
            m_pos   = 0;
            m_valid = 1'b1;
        end else begin
            m_pos++;
        end
    endtask

    task automatic model_reset();
        m_pos   = 0;
        m_mode  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input vec_t e);
        chk({tag, ".busy"},  int'(busy_out),         int'(e.busy));
        chk({tag, ".load"},  int'(load_out),         int'(e.load));
        chk({tag, ".en"},    int'(en_out),           int'(e.en));
        chk({tag, ".iter"},  int'(iter_out),         e.iter);
        chk({tag, ".dir"},   int'(dir_out),          int'(e.dir));
        chk({tag, ".done"},  int'(done_out),         int'(e.done));
        chk({tag, ".valid"}, int'(result_valid_out), int'(e.valid));
    endtask

    task automatic check_zero(input string tag);
        vec_t z;
        z = run_vec(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_outs(tag, z);
    endtask

    task automatic apply(input vec_t v);
        start_in  = v.start;
        mode_in   = v.mode;
        z_sign_in = v.zs;
        y_sign_in = v.ys;
    endtask

    // One clock cycle: drive, check mid-cycle, clock, advance the model.
    task automatic cycle(input vec_t v, input bit use_tab, input string tag);
        apply(v);
        #1;
        if (use_tab) check_outs(tag, v);
        else         check_outs(tag, model_vec(v));
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    function automatic vec_t stim(input logic st, input logic md,
                                  input logic zs, input logic ys);
        vec_t v;
        v = run_vec(0, st, md, zs, ys, 1'b0, 1'b0);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic dmode;

        for (int c = 0; c < TL; c++) begin
            tab_rot[c] = run_vec(c, c == 0, 1'b0, (c % 2) == 1,
                                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            tab_vec[c] = run_vec(c, c == 0, 1'b1, 1'($urandom_range(0, 1)),
                                 1'b0, 1'b1, 1'b1);
            dmode = (c < 5) ? 1'b1 : 1'b0;
            tab_dist[c] = run_vec(c, (c == 0) || (c == 3) || (c == N + 2), dmode,
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'b1, 1'b1);
        end

        // Asynchronous reset before any clock edge.
        #2 rst_in = 1'b1;
        z_sign_in = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        @(posedge clk);
        #3 rst_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cycle(stim(1'b0, 1'b0, 1'b1, 1'b0), 1'b0, "idle_after_rst");

        for (int c = 0; c < TL; c++) cycle(tab_rot[c],  1'b1, $sformatf("rot[%0d]", c));
        for (int c = 0; c < TL; c++) cycle(tab_vec[c],  1'b1, $sformatf("vec[%0d]", c));
        for (int c = 0; c < TL; c++) cycle(tab_dist[c], 1'b1, $sformatf("dist[%0d]", c));

        // start_in held high: accepts at 0, N+3, 2(N+3).
        for (int c = 0; c < 3 * (N + 3) + 1; c++) begin
            v = stim(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            apply(v);
            #1;
            check_outs($sformatf("hold[%0d]", c), model_vec(v));
            if (c == 1 || c == N + 4 || c == 2 * N + 7)
                chk($sformatf("hold_load[%0d]", c), int'(load_out), 1);
            if (c == N + 2 || c == 2 * N + 5 || c == 3 * N + 8)
                chk($sformatf("hold_done[%0d]", c), int'(done_out), 1);
            if (c == N + 3) chk("hold_valid_set", int'(result_valid_out), 1);
            if (c == N + 4) chk("hold_valid_clr", int'(result_valid_out), 0);
            @(posedge clk);
            model_step(v);
            #1;
        end

        for (int k = 0; k < 400; k++) begin
            v = stim($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle(v, 1'b0, $sformatf("rand[%0d]", k));
        end
        for (int k = 0; k < N + 3 && m_pos != 0; k++)
            cycle(stim(1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "drain");

        // Abort a rotation run at iteration 5 with an asynchronous reset.
        for (int c = 0; c < 7; c++) cycle(stim(c == 0, 1'b0, 1'b1, 1'b0), 1'b0, "abort_run");
        v = stim(1'b0, 1'b0, 1'b1, 1'b0);
        apply(v);
        #1;
        check_outs("abort_pre", model_vec(v));
        chk("abort_iter5", int'(iter_out), 5);
        #1 rst_in = 1'b1;
        #1 check_zero("abort_rst");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", int'(done_out), 0);
            chk("abort_no_busy", int'(busy_out), 0);
            chk("abort_iter0",   int'(iter_out), 0);
        end
        #2 rst_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cycle(stim(1'b0, 1'b1, 1'b1, 1'b0), 1'b0, "idle_after_abort");
        for (int c = 0; c < TL; c++) cycle(tab_rot[c], 1'b1, $sformatf("rot2[%0d]", c));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencer for the iterative CORDIC datapath. It accepts a start request and loads the initial x/y/z operands into the datapath registers. It then steps the datapath through NUM_ITER micro-rotations, supplying the shift amount / arctan-table index and the rotation direction each cycle, and signals completion. It sits between the host-side request logic and the x/y/z register bank; it holds no datapath values itself.

## Interface
- BIT_WIDTH, 16: datapath word width; used only for the NUM_ITER legality check.
- NUM_ITER, 12: number of micro-rotations; legal range 2..BIT_WIDTH.
- CNT_W, $clog2(NUM_ITER): width of the iteration index (derived; not overridden).

- clk  in  1  rising-edge clock.
- rst_in  in  1  reset; asynchronous, active-high.
- start_in  in  1  request a new computation; sampled only in IDLE.
- mode_in  in  1  0 = rotation, 1 = vectoring; captured with start_in.
- z_sign_in  in  1  MSB of the z register (1 = negative).
- y_sign_in  in  1  MSB of the y register (1 = negative).
- busy_out  out  1  high from the cycle after start is accepted through DONE.
- load_out  out  1  selects initial operands into the x/y/z registers.
- en_out  out  1  write enable for the x/y/z registers.
- iter_out  out  CNT_W  current iteration index i (shift amount, atan index).
- dir_out  out  1  1 = d_i = −1 (x += y>>i, y −= x>>i, z += atan_i); 0 = d_i = +1.
- done_out  out  1  one-cycle pulse: the result is in the registers.
- result_valid_out  out  1  level: the result is valid; cleared on the next accepted start.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: start_in=1 → LOAD. The mode is latched on the same edge and result_valid_out is cleared.
- LOAD: load_out=1 and en_out=1 for exactly one cycle → ITER, with iteration index i cleared to 0.
- ITER: en_out=1 every cycle. i increments by 1 per cycle. At i==NUM_ITER−1 → DONE. The index does not wrap: it holds at 0 outside ITER.
- DONE: done_out=1 for one cycle and result_valid_out is set → IDLE.
- dir_out is combinational and is forced to 0 outside ITER:
  - rotation: dir_out = z_sign_in.
  - vectoring: dir_out = ~y_sign_in (y ≥ 0 drives y toward 0 with d = −1).
- start_in outside IDLE (LOAD/ITER/DONE) is ignored. It is not queued.
- A change on mode_in after acceptance has no effect until the next start.
- Reset (any state, asynchronous): state=IDLE, i=0, latched mode=0.
  - All outputs are 0, including result_valid_out.
  - An aborted run never produces done_out.

## Timing
- Cycle 0 is the edge where start_in is sampled high in IDLE.
- LOAD occupies cycle 1.
- ITER occupies cycles 2..NUM_ITER+1, with iter_out = 0..NUM_ITER−1.
- done_out is high in cycle NUM_ITER+2.
- Start-to-done latency is NUM_ITER+2 cycles. With the default parameters, done_out is high 14 cycles after start.
- The earliest next start is sampled in cycle NUM_ITER+3 (IDLE). Throughput is one result per NUM_ITER+3 cycles.
- busy_out, load_out, en_out, done_out and iter_out are Moore outputs decoded from registered state. They have no combinational path from inputs.
- dir_out has a combinational path from z_sign_in/y_sign_in (same-cycle sign of the current register value).
- result_valid_out is registered.

## Structure
- Shared package cordic_pkg holds:
  - the state typedef: enum IDLE/LOAD/ITER/DONE;
  - the constants MODE_ROT=1'b0 and MODE_VEC=1'b1;
  - the direction constants DIR_POS=1'b0 and DIR_NEG=1'b1.
- One sub-module, cordic_iter_cnt, is natural:
  - CNT_W-bit counter with clear, enable and a terminal-count flag (i==NUM_ITER−1);
  - asynchronous active-high reset.
- The FSM, mode latch and direction decode stay in cordic_seq_ctrl.
- An elaboration-time check rejects NUM_ITER<2 or NUM_ITER>BIT_WIDTH.

## Test plan
- Reset: assert rst_in mid-cycle with no clock edge. Required: all outputs 0 immediately. Release, idle 3 cycles: outputs remain 0.
- Rotation run (NUM_ITER=12, mode_in=0), start pulse at cycle 0, z_sign_in toggled every cycle. Required:
  - load_out high in cycle 1 only;
  - iter_out 0..11 in cycles 2..13;
  - dir_out equals z_sign_in in each of those cycles;
  - done_out high in cycle 14 only, result_valid_out=1 from cycle 15.
- Vectoring run (mode_in=1, y_sign_in=0 held). Required: dir_out=1 for all 12 ITER cycles and 0 in LOAD/DONE/IDLE.
- start_in held high continuously. Required: runs accepted at cycles 0, 15, 30. Each run has done_out at +14 and result_valid_out drops for the cycles between each accepted start and its done_out.
- Extra start pulses at cycles 3 and 14, and a mode_in flip at cycle 5. Required: no restart; timing and dir_out identical to an undisturbed run.
- rst_in pulse while iter_out=5. Required: outputs 0 at once and no done_out. A start after release yields a full 14-cycle run starting at iter_out=0.
